// File: rtl/btn_pkg.sv
// Shared constants for the direction-button conditioner: button indices,
// button count and default timing at a 100 MHz board clock.
package btn_pkg;

  localparam int unsigned NUM_BTN = 4;

  // Bit positions of each direction button on the btn_* vectors
  typedef enum logic [1:0] {
    BTN_UP    = 2'd0,
    BTN_DOWN  = 2'd1,
    BTN_LEFT  = 2'd2,
    BTN_RIGHT = 2'd3
  } btn_idx_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms
  localparam int unsigned DEF_COMBO_HOLD      = 5_000_000;  // 50 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 40_000_000; // 400 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000; // 100 ms

  // Larger of two cycle counts, used to size shared counters
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button bit: 2-FF synchroniser into a counter debouncer. The settled
// level is registered; rise_c/fall_c flag the cycle in which it will change
// so the parent can register its pulses alongside the level.
module debounce_bit
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             settle_c;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count cycles of disagreement; adopt the new value after a full window
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    settle_c = 1'b0;
    if (sync_q2 != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        settle_c = 1'b1;
        stable_d = sync_q2;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level  = stable_q;
  assign rise_c = settle_c & sync_q2;
  assign fall_c = settle_c & ~sync_q2;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw direction buttons for the game top: debounced
// levels, one-cycle press/release pulses and a held all-four combo used to
// leave the game-over screen.
// Optional build macro AUTO_REPEAT_EN adds held-button auto-repeat presses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned COMBO_HOLD      = DEF_COMBO_HOLD,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press,
  output logic               combo_all,
  output logic               combo_pulse
);

  // Reject configurations whose counters would collapse to zero width
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (COMBO_HOLD < 1) begin : g_bad_combo
    $error("COMBO_HOLD must be at least 1");
  end
  if (max_u(REPEAT_DELAY, REPEAT_PERIOD) < 2 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY/REPEAT_PERIOD too small");
  end

  localparam int unsigned CMB_W = $clog2(COMBO_HOLD + 1);
  localparam logic [CMB_W-1:0] CMB_FULL = CMB_W'(COMBO_HOLD);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] rise_w;
  logic [NUM_BTN-1:0] fall_w;
  logic [NUM_BTN-1:0] rep_fire_c;
  logic [NUM_BTN-1:0] press_c;
  logic               all_held_c;
  logic               combo_hit_c;
  logic [CMB_W-1:0]   combo_cnt_q;
  logic [CMB_W-1:0]   combo_cnt_d;

  // Per-button synchroniser and debouncer
  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (level_w[i]),
      .rise_c(rise_w[i]),
      .fall_c(fall_w[i])
    );
  end

  assign btn_level = level_w;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0][REP_W-1:0] rep_cnt_q;
  logic [NUM_BTN-1:0][REP_W-1:0] rep_cnt_d;
  logic [NUM_BTN-1:0]            rep_periodic_q;
  logic [NUM_BTN-1:0]            rep_periodic_d;

  // Repeat timer per button: initial delay after the press, then periodic
  always_comb begin
    rep_cnt_d      = rep_cnt_q;
    rep_periodic_d = rep_periodic_q;
    rep_fire_c     = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (!level_w[i]) begin
        rep_cnt_d[i]      = '0;
        rep_periodic_d[i] = 1'b0;
      end else if (rep_cnt_q[i] == (rep_periodic_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
        rep_fire_c[i]     = 1'b1;
        rep_cnt_d[i]      = '0;
        rep_periodic_d[i] = 1'b1;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
      end
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q      <= '0;
      rep_periodic_q <= '0;
    end else begin
      rep_cnt_q      <= rep_cnt_d;
      rep_periodic_q <= rep_periodic_d;
    end
  end
`else
  assign rep_fire_c = '0;
`endif

  assign press_c = rise_w | rep_fire_c;

  // Saturating hold counter for the all-four combo
  always_comb begin
    all_held_c  = level_w[BTN_UP] & level_w[BTN_DOWN] & level_w[BTN_LEFT] & level_w[BTN_RIGHT];
    combo_cnt_d = '0;
    if (all_held_c) begin
      combo_cnt_d = (combo_cnt_q == CMB_FULL) ? combo_cnt_q : combo_cnt_q + CMB_W'(1);
    end
    combo_hit_c = (combo_cnt_d == CMB_FULL);
  end

  // Registered pulses and combo outputs, aligned with the level change
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
      combo_cnt_q <= '0;
      combo_all   <= 1'b0;
      combo_pulse <= 1'b0;
    end else begin
      btn_press   <= press_c;
      btn_release <= fall_w;
      any_press   <= |press_c;
      combo_cnt_q <= combo_cnt_d;
      combo_all   <= combo_hit_c;
      combo_pulse <= combo_hit_c & ~combo_all;
    end
  end

endmodule
